// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        TRAP  = 2'd3
    } pc_state_t;

    localparam word_t PC_INCR = 32'd4;

    function automatic logic is_misaligned(input word_t addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Branch decision and next-PC selection: target when branch&zero, else PC+4.
module pc_next_sel
    import pc_seq_pkg::*;
(
    input  word_t pc_i,
    input  logic  branch_i,
    input  logic  zero_i,
    input  word_t offset_i,
    output word_t pc_next_o,
    output logic  take_o
);

    // Both sums wrap modulo 2^32; the offset is two's-complement so a plain add suffices.
    assign take_o    = branch_i & zero_i;
    assign pc_next_o = take_o ? (pc_i + offset_i) : (pc_i + PC_INCR);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute PC sequencer with a ready handshake to instruction memory.
// Optional PC_SEQ_MISALIGN_TRAP_EN: misaligned next-PC enters a terminal TRAP state.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        branch,
    input  logic        zero,
    input  logic [31:0] branchOffset,
    input  logic        stall,
    input  logic        fetchReady,
    output logic        fetchReq,
    output logic [31:0] fetchAddr,
    output logic [31:0] PC,
    output logic [31:0] PCNext,
    output logic        instrValid,
    output logic        branchTaken,
    output logic [31:0] instrCount
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    ,
    output logic        misaligned
`endif
);

    pc_state_t state_q, state_d;
    word_t     pc_q, pc_d;
    word_t     cnt_q, cnt_d;
    logic      taken_q, taken_d;
    word_t     pc_next;
    logic      take;

    pc_next_sel u_next_sel (
        .pc_i      (pc_q),
        .branch_i  (branch),
        .zero_i    (zero),
        .offset_i  (branchOffset),
        .pc_next_o (pc_next),
        .take_o    (take)
    );

`ifdef PC_SEQ_MISALIGN_TRAP_EN
    logic mis_q, mis_d;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        taken_d = 1'b0;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        mis_d   = mis_q;
`endif
        case (state_q)
            BOOT:  state_d = FETCH;
            FETCH: if (fetchReady) state_d = EXEC;
            EXEC: begin
                // A stall holds everything, including a pending taken branch.
                if (!stall) begin
`ifdef PC_SEQ_MISALIGN_TRAP_EN
                    if (is_misaligned(pc_next)) begin
                        state_d = TRAP;
                        mis_d   = 1'b1;
                    end else begin
                        pc_d    = pc_next;
                        cnt_d   = cnt_q + 32'd1;
                        taken_d = take;
                        state_d = FETCH;
                    end
`else
                    pc_d    = {pc_next[31:2], 2'b00};
                    cnt_d   = cnt_q + 32'd1;
                    taken_d = take;
                    state_d = FETCH;
`endif
                end
            end
`ifdef PC_SEQ_MISALIGN_TRAP_EN
            TRAP:  state_d = TRAP;
`endif
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            taken_q <= taken_d;
        end
    end

`ifdef PC_SEQ_MISALIGN_TRAP_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) mis_q <= 1'b0;
        else        mis_q <= mis_d;
    end
    assign misaligned = mis_q;
`endif

    assign fetchReq    = (state_q == FETCH);
    assign fetchAddr   = pc_q;
    assign PC          = pc_q;
    assign PCNext      = pc_next;
    assign instrValid  = (state_q == EXEC);
    assign branchTaken = taken_q;
    assign instrCount  = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer; each task drives one scenario and checks inline.
module tb_pc_sequencer;

    logic        clock, reset, branch, zero, stall, fetchReady;
    logic [31:0] branchOffset;
    logic        fetchReq, instrValid, branchTaken;
    logic [31:0] fetchAddr, PC, PCNext, instrCount;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    int vectors = 0;
    int miscompares = 0;

    pc_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .branch       (branch),
        .zero         (zero),
        .branchOffset (branchOffset),
        .stall        (stall),
        .fetchReady   (fetchReady),
        .fetchReq     (fetchReq),
        .fetchAddr    (fetchAddr),
        .PC           (PC),
        .PCNext       (PCNext),
        .instrValid   (instrValid),
        .branchTaken  (branchTaken),
        .instrCount   (instrCount)
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        ,
        .misaligned   (misaligned)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
        $display("t=%0t PC=%h fetchReq=%0b instrValid=%0b branchTaken=%0b instrCount=%0d",
                 $time, PC, fetchReq, instrValid, branchTaken, instrCount);
    endtask

    task automatic test_reset();
        #3;
        if (PC !== 32'h0) begin miscompares++; $display("FAIL rst_pc: got %h want %h", PC, 32'h0); end vectors++;
        if (fetchReq !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b want 0", fetchReq); end vectors++;
        if (instrValid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", instrValid); end vectors++;
        if (branchTaken !== 1'b0) begin miscompares++; $display("FAIL rst_bt: got %b want 0", branchTaken); end vectors++;
        if (instrCount !== 32'h0) begin miscompares++; $display("FAIL rst_cnt: got %h want 0", instrCount); end vectors++;
        if (PCNext !== 32'h4) begin miscompares++; $display("FAIL rst_pcnext: got %h want %h", PCNext, 32'h4); end vectors++;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        if (misaligned !== 1'b0) begin miscompares++; $display("FAIL rst_mis: got %b want 0", misaligned); end vectors++;
`endif
        @(posedge clock);
        #1;
        reset = 1'b1;
        if (fetchReq !== 1'b0) begin miscompares++; $display("FAIL boot_req: got %b want 0", fetchReq); end vectors++;
        step();
        if (fetchReq !== 1'b1) begin miscompares++; $display("FAIL fetch_req: got %b want 1", fetchReq); end vectors++;
        if (fetchAddr !== 32'h0) begin miscompares++; $display("FAIL fetch_addr: got %h want 0", fetchAddr); end vectors++;
    endtask

    task automatic test_sequence();
        fetchReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (instrValid !== 1'b1) begin miscompares++; $display("FAIL seq_valid%0d: got %b want 1", i, instrValid); end vectors++;
            if (PC !== 32'(i * 4)) begin miscompares++; $display("FAIL seq_pc%0d: got %h want %h", i, PC, 32'(i * 4)); end vectors++;
            if (i < 3) begin
                step();
                if (instrCount !== 32'(i + 1)) begin miscompares++; $display("FAIL seq_cnt%0d: got %0d want %0d", i, instrCount, i + 1); end vectors++;
                if (fetchReq !== 1'b1) begin miscompares++; $display("FAIL seq_req%0d: got %b want 1", i, fetchReq); end vectors++;
            end
        end
    endtask

    task automatic test_branch();
        branch = 1'b1; zero = 1'b1; branchOffset = 32'h0000_00F4;
        #1;
        if (PCNext !== 32'h100) begin miscompares++; $display("FAIL br_pcnext0: got %h want %h", PCNext, 32'h100); end vectors++;
        step();
        if (PC !== 32'h100) begin miscompares++; $display("FAIL br_pc0: got %h want %h", PC, 32'h100); end vectors++;
        if (branchTaken !== 1'b1) begin miscompares++; $display("FAIL br_bt0: got %b want 1", branchTaken); end vectors++;
        if (instrCount !== 32'd4) begin miscompares++; $display("FAIL br_cnt0: got %0d want 4", instrCount); end vectors++;
        step();
        if (branchTaken !== 1'b0) begin miscompares++; $display("FAIL br_btclr0: got %b want 0", branchTaken); end vectors++;
        branchOffset = 32'hFFFF_FFF0;
        #1;
        if (PCNext !== 32'hF0) begin miscompares++; $display("FAIL br_pcnext1: got %h want %h", PCNext, 32'hF0); end vectors++;
        step();
        if (PC !== 32'hF0) begin miscompares++; $display("FAIL br_pc1: got %h want %h", PC, 32'hF0); end vectors++;
        if (branchTaken !== 1'b1) begin miscompares++; $display("FAIL br_bt1: got %b want 1", branchTaken); end vectors++;
        step();
        if (branchTaken !== 1'b0) begin miscompares++; $display("FAIL br_btclr1: got %b want 0", branchTaken); end vectors++;
        branchOffset = 32'h10;
        step();
        if (PC !== 32'h100) begin miscompares++; $display("FAIL br_pc2: got %h want %h", PC, 32'h100); end vectors++;
        step();
        zero = 1'b0; branchOffset = 32'hFFFF_FFF0;
        #1;
        if (PCNext !== 32'h104) begin miscompares++; $display("FAIL nt_pcnext: got %h want %h", PCNext, 32'h104); end vectors++;
        step();
        if (PC !== 32'h104) begin miscompares++; $display("FAIL nt_pc: got %h want %h", PC, 32'h104); end vectors++;
        if (branchTaken !== 1'b0) begin miscompares++; $display("FAIL nt_bt: got %b want 0", branchTaken); end vectors++;
        if (instrCount !== 32'd7) begin miscompares++; $display("FAIL nt_cnt: got %0d want 7", instrCount); end vectors++;
        branch = 1'b0;
    endtask

    task automatic test_fetch_wait();
        fetchReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (fetchReq !== 1'b1) begin miscompares++; $display("FAIL fw_req%0d: got %b want 1", i, fetchReq); end vectors++;
            if (fetchAddr !== 32'h104) begin miscompares++; $display("FAIL fw_addr%0d: got %h want %h", i, fetchAddr, 32'h104); end vectors++;
            if (instrValid !== 1'b0) begin miscompares++; $display("FAIL fw_valid%0d: got %b want 0", i, instrValid); end vectors++;
            if (i < 3) step();
        end
        fetchReady = 1'b1;
        step();
        if (instrValid !== 1'b1) begin miscompares++; $display("FAIL fw_exec: got %b want 1", instrValid); end vectors++;
        if (PC !== 32'h104) begin miscompares++; $display("FAIL fw_pc: got %h want %h", PC, 32'h104); end vectors++;
    endtask

    task automatic test_stall();
        stall = 1'b1; branch = 1'b1; zero = 1'b1; branchOffset = 32'h20;
        for (int i = 0; i < 2; i++) begin
            step();
            if (instrValid !== 1'b1) begin miscompares++; $display("FAIL st_valid%0d: got %b want 1", i, instrValid); end vectors++;
            if (PC !== 32'h104) begin miscompares++; $display("FAIL st_pc%0d: got %h want %h", i, PC, 32'h104); end vectors++;
            if (instrCount !== 32'd7) begin miscompares++; $display("FAIL st_cnt%0d: got %0d want 7", i, instrCount); end vectors++;
            if (branchTaken !== 1'b0) begin miscompares++; $display("FAIL st_bt%0d: got %b want 0", i, branchTaken); end vectors++;
        end
        stall = 1'b0;
        step();
        if (PC !== 32'h124) begin miscompares++; $display("FAIL st_pc: got %h want %h", PC, 32'h124); end vectors++;
        if (branchTaken !== 1'b1) begin miscompares++; $display("FAIL st_bt: got %b want 1", branchTaken); end vectors++;
        if (instrCount !== 32'd8) begin miscompares++; $display("FAIL st_cnt: got %0d want 8", instrCount); end vectors++;
        branch = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        step();
        branch = 1'b1; zero = 1'b1; branchOffset = 32'hFFFF_FEFC;
        step();
        branch = 1'b0;
        if (PC !== 32'h20) begin miscompares++; $display("FAIL rm_pc20: got %h want %h", PC, 32'h20); end vectors++;
        fetchReady = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        if (fetchReq !== 1'b0) begin miscompares++; $display("FAIL rm_req: got %b want 0", fetchReq); end vectors++;
        if (PC !== 32'h0) begin miscompares++; $display("FAIL rm_pc: got %h want 0", PC); end vectors++;
        if (instrCount !== 32'h0) begin miscompares++; $display("FAIL rm_cnt: got %0d want 0", instrCount); end vectors++;
        if (branchTaken !== 1'b0) begin miscompares++; $display("FAIL rm_bt: got %b want 0", branchTaken); end vectors++;
        #1;
        reset = 1'b1;
        #1;
        if (fetchReq !== 1'b0) begin miscompares++; $display("FAIL rm_boot: got %b want 0", fetchReq); end vectors++;
        step();
        if (fetchReq !== 1'b1) begin miscompares++; $display("FAIL rm_refetch: got %b want 1", fetchReq); end vectors++;
        if (fetchAddr !== 32'h0) begin miscompares++; $display("FAIL rm_addr: got %h want 0", fetchAddr); end vectors++;
        fetchReady = 1'b1;
    endtask

    task automatic test_wrap();
        step();
        branch = 1'b1; zero = 1'b1; branchOffset = 32'hFFFF_FFFC;
        step();
        branch = 1'b0;
        if (PC !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wr_top: got %h want %h", PC, 32'hFFFF_FFFC); end vectors++;
        step();
        if (PCNext !== 32'h0) begin miscompares++; $display("FAIL wr_pcnext: got %h want 0", PCNext); end vectors++;
        step();
        if (PC !== 32'h0) begin miscompares++; $display("FAIL wr_pc: got %h want 0", PC); end vectors++;
        if (instrCount !== 32'd2) begin miscompares++; $display("FAIL wr_cnt: got %0d want 2", instrCount); end vectors++;
        step();
        branch = 1'b1;
        step();
        step();
        branchOffset = 32'h2;
        #1;
        if (PCNext !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL mis_pcnext: got %h want %h", PCNext, 32'hFFFF_FFFE); end vectors++;
        step();
        branch = 1'b0;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            if (misaligned !== 1'b1) begin miscompares++; $display("FAIL trap_mis%0d: got %b want 1", i, misaligned); end vectors++;
            if (fetchReq !== 1'b0) begin miscompares++; $display("FAIL trap_req%0d: got %b want 0", i, fetchReq); end vectors++;
            if (instrValid !== 1'b0) begin miscompares++; $display("FAIL trap_valid%0d: got %b want 0", i, instrValid); end vectors++;
            if (PC !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL trap_pc%0d: got %h want %h", i, PC, 32'hFFFF_FFFC); end vectors++;
            if (instrCount !== 32'd3) begin miscompares++; $display("FAIL trap_cnt%0d: got %0d want 3", i, instrCount); end vectors++;
            step();
        end
`else
        if (PC !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL mask_pc: got %h want %h", PC, 32'hFFFF_FFFC); end vectors++;
        if (fetchReq !== 1'b1) begin miscompares++; $display("FAIL mask_req: got %b want 1", fetchReq); end vectors++;
        if (branchTaken !== 1'b1) begin miscompares++; $display("FAIL mask_bt: got %b want 1", branchTaken); end vectors++;
        if (instrCount !== 32'd4) begin miscompares++; $display("FAIL mask_cnt: got %0d want 4", instrCount); end vectors++;
`endif
    endtask

    initial begin
        reset = 1'b0; branch = 1'b0; zero = 1'b0; stall = 1'b0;
        fetchReady = 1'b0; branchOffset = 32'h0;
        test_reset();
        test_sequence();
        test_branch();
        test_fetch_wait();
        test_stall();
        test_reset_mid_fetch();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the single-issue RISC-V datapath. It owns the PC register and runs a fetch/execute state machine with a ready handshake to instruction memory. In the execute cycle it registers the branch decision (branch AND zero) and advances the PC to PC+4 or to the branch target. It replaces the free-running PC update path and feeds the fetch address to instruction memory and the current PC to the datapath adders.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clock  input  1  rising-edge system clock
- reset  input  1  asynchronous, active-low reset
- branch  input  1  branch signal from the controller, valid in EXEC
- zero  input  1  zero flag from the ALU, valid in EXEC
- branchOffset  input  32  byte offset, already shifted, from the immediate shift unit; added to PC
- stall  input  1  holds the sequencer in EXEC
- fetchReady  input  1  instruction memory has data for fetchAddr
- fetchReq  output  1  fetch request to instruction memory
- fetchAddr  output  32  fetch address, equal to PC
- PC  output  32  current PC register
- PCNext  output  32  combinational next PC: target if branch&zero, else PC+4
- instrValid  output  1  high during EXEC; the instruction word is valid
- branchTaken  output  1  one-cycle pulse after a taken branch updates PC
- instrCount  output  32  count of retired instructions
- misaligned  output  1  sticky misaligned-target flag (only with PC_SEQ_MISALIGN_TRAP_EN)

## Operation
- States: BOOT, FETCH, EXEC, TRAP. TRAP exists only when the macro is defined.
- BOOT: all outputs idle. Goes to FETCH on the next edge.
- FETCH: fetchReq=1 and fetchAddr=PC. Goes to EXEC on an edge where fetchReady=1; otherwise stays in FETCH.
- EXEC: instrValid=1.
  - stall=1 at the edge: stay in EXEC. PC, instrCount and branchTaken are unchanged. branch and zero are re-sampled at the next edge.
  - stall=0 at the edge: PC <= PCNext, instrCount += 1, branchTaken <= branch&zero, then go to FETCH.
- PCNext arithmetic:
  - PC+4 and PC+branchOffset are computed modulo 2^32 and wrap silently.
  - branchOffset is treated as two's-complement.
- branch and zero are sampled only in EXEC. They are don't-care in every other state.
- fetchReady is ignored outside FETCH.
- Simultaneous stall and taken branch: stall wins and no PC update occurs.
- instrCount wraps from 32'hFFFF_FFFF to 0.

## Timing
- Reset values: state=BOOT, PC=RESET_PC, fetchReq=0, instrValid=0, branchTaken=0, instrCount=0, misaligned=0.
- Reset mid-operation: all registers clear asynchronously. fetchReq drops in the same instant. An in-flight fetch is abandoned, and memory must tolerate the request dropping.
- Minimum rate is 2 cycles per instruction: 1 FETCH cycle with fetchReady=1, then 1 EXEC cycle.
- Each fetch wait cycle adds 1 cycle. Each stall cycle adds 1 cycle.
- PC and fetchAddr change only on the edge that leaves EXEC.
- branchTaken is high for exactly the FETCH cycle that follows a taken branch.
- PCNext is combinational from PC, branch, zero and branchOffset, and has zero latency.

## Configuration
- PC_SEQ_MISALIGN_TRAP_EN defined:
  - If the selected PCNext has bits [1:0] != 0 when leaving EXEC, go to TRAP instead of FETCH.
  - PC is not updated, misaligned sets to 1, and instrCount is not incremented.
  - TRAP is terminal until reset, with fetchReq=0.
- PC_SEQ_MISALIGN_TRAP_EN undefined:
  - PCNext bits [1:0] are forced to 0 before the PC load.
  - The misaligned port and the TRAP state are absent.

## Structure
- Shared package pc_seq_pkg holds:
  - the state enum type pc_state_t (BOOT, FETCH, EXEC, TRAP)
  - the constant PC_INCR = 32'd4
  - the 32-bit word typedef used across the datapath
- One sub-module: pc_next_sel, a combinational branch-decision and next-PC adder/mux. The FSM, PC register and counter stay in pc_sequencer.

## Test plan
- Reset then run, fetchReady tied to 1, branch=0 → PC sequence 0, 4, 8, 12 in EXEC cycles 2 cycles apart; instrCount=3 after third EXEC exit.
- EXEC with PC=0x100, branch=1, zero=1, branchOffset=0xFFFF_FFF0 → PC=0xF0, branchTaken pulses for 1 cycle; same with zero=0 → PC=0x104, no pulse.
- fetchReady held low 3 cycles in FETCH → fetchReq and fetchAddr stable for 4 cycles, EXEC entered after the ready edge, PC unchanged.
- stall=1 for 2 EXEC cycles with branch&zero=1 → PC held, instrCount held, then a single update to the target when stall drops.
- reset asserted mid-FETCH at PC=0x20 → fetchReq=0 immediately, PC=RESET_PC, state BOOT; recovery fetches RESET_PC.
- PC=0xFFFF_FFFC, no branch → PC wraps to 0; with macro defined, branchOffset=0x2 taken → TRAP, misaligned=1, PC stays 0xFFFF_FFFC.
